// File: rtl/alarm_dispatch_ctrl.sv
// Alarm dispatch: per-zone persistence latching, cadenced siren FSM and a dialer handshake with timeout/retry.
// Optional macro ALARM_SILENCE_TIMEOUT_EN: SILENCED resounds to ALARM after SILENCE_CYCLES cycles.
module alarm_dispatch_ctrl #(
    parameter int ZONES          = 4,
    parameter int PERSIST        = 3,
    parameter int CADENCE        = 8,
    parameter int CALL_TIMEOUT   = 16,
    parameter int MAX_RETRY      = 3,
    parameter int SILENCE_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [ZONES-1:0] fire_alarm,
    input  logic             call,
    input  logic             silence,
    input  logic             clear,
    input  logic             dial_ack,
    output logic [ZONES-1:0] zone_latched,
    output logic             siren,
    output logic             dial_req,
    output logic             dial_fail,
    output logic [1:0]       alarm_state
);

    localparam int PW = $clog2(PERSIST + 1);
    localparam int CW = $clog2(CADENCE + 1);
    localparam int TW = $clog2(CALL_TIMEOUT + 1);
    localparam int AW = $clog2(MAX_RETRY + 1);
    localparam logic [PW-1:0] P_MAX  = PW'(PERSIST);
    localparam logic [PW-1:0] P_LAST = PW'(PERSIST - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CADENCE - 1);
    localparam logic [TW-1:0] T_LAST = TW'(CALL_TIMEOUT - 1);
    localparam logic [AW-1:0] A_MAX  = AW'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ALARM    = 2'b01,
        ST_SILENCED = 2'b10
    } main_state_t;

    typedef enum logic [2:0] {
        C_IDLE,
        C_REQ,
        C_GAP,
        C_DONE,
        C_FAIL
    } dial_state_t;

    logic [PW-1:0]    zone_cnt      [ZONES];
    logic [PW-1:0]    zone_cnt_next [ZONES];
    logic [ZONES-1:0] zone_set, zone_next, zone_prev;
    logic [PW-1:0]    call_cnt, call_cnt_next;
    logic             call_set, call_latched, call_latched_next;

    main_state_t      state, state_next;
    logic             siren_next, new_latch;
    logic [CW-1:0]    cad_cnt, cad_next;

    dial_state_t      dstate, dstate_next;
    logic [TW-1:0]    timer, timer_next;
    logic [AW-1:0]    attempt, attempt_next;

`ifdef ALARM_SILENCE_TIMEOUT_EN
    localparam int SW = $clog2(SILENCE_CYCLES + 1);
    localparam logic [SW-1:0] S_LAST = SW'(SILENCE_CYCLES - 1);
    logic [SW-1:0] sil_cnt, sil_next;
`endif

    // A latch sets on the PERSIST-th consecutive high sample; clear only releases inputs that are low.
    always_comb begin
        zone_set  = '0;
        zone_next = '0;
        for (int i = 0; i < ZONES; i++) begin
            zone_cnt_next[i] = '0;
            if (fire_alarm[i])
                zone_cnt_next[i] = (zone_cnt[i] == P_MAX) ? P_MAX : zone_cnt[i] + PW'(1);
            zone_set[i]  = fire_alarm[i] && (zone_cnt[i] >= P_LAST);
            zone_next[i] = zone_set[i] || (zone_latched[i] && !(clear && !fire_alarm[i]));
        end
        call_cnt_next = '0;
        if (call)
            call_cnt_next = (call_cnt == P_MAX) ? P_MAX : call_cnt + PW'(1);
        call_set          = call && (call_cnt >= P_LAST);
        call_latched_next = call_set || (call_latched && !(clear && !call));
    end

    assign new_latch = |(zone_latched & ~zone_prev);

    always_comb begin
        state_next = state;
        siren_next = 1'b0;
        cad_next   = '0;
`ifdef ALARM_SILENCE_TIMEOUT_EN
        sil_next   = '0;
`endif
        case (state)
            ST_IDLE: begin
                if (|zone_latched)
                    state_next = ST_ALARM;
            end
            ST_ALARM: begin
                if (zone_latched == '0)
                    state_next = ST_IDLE;
                else if (silence && !new_latch)
                    state_next = ST_SILENCED;
            end
            ST_SILENCED: begin
                if (zone_latched == '0)
                    state_next = ST_IDLE;
                else if (new_latch)
                    state_next = ST_ALARM;
`ifdef ALARM_SILENCE_TIMEOUT_EN
                else if (sil_cnt == S_LAST)
                    state_next = ST_ALARM;
                else
                    sil_next = sil_cnt + SW'(1);
`endif
            end
            default: state_next = ST_IDLE;
        endcase

        // Every entry into ALARM restarts the cadence on its high half.
        if (state_next == ST_ALARM) begin
            if (state != ST_ALARM) begin
                siren_next = 1'b1;
            end else if (cad_cnt == C_LAST) begin
                siren_next = !siren;
            end else begin
                siren_next = siren;
                cad_next   = cad_cnt + CW'(1);
            end
        end
    end

    // An ack that coincides with the timeout edge is treated as success.
    always_comb begin
        dstate_next  = dstate;
        timer_next   = timer;
        attempt_next = attempt;
        case (dstate)
            C_IDLE: begin
                if (call_latched) begin
                    dstate_next  = C_REQ;
                    attempt_next = AW'(1);
                    timer_next   = '0;
                end
            end
            C_REQ: begin
                if (dial_ack)
                    dstate_next = C_DONE;
                else if (timer == T_LAST)
                    dstate_next = (attempt == A_MAX) ? C_FAIL : C_GAP;
                else
                    timer_next = timer + TW'(1);
            end
            C_GAP: begin
                dstate_next  = C_REQ;
                attempt_next = attempt + AW'(1);
                timer_next   = '0;
            end
            C_DONE, C_FAIL: begin
                if (!call_latched)
                    dstate_next = C_IDLE;
            end
            default: dstate_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ZONES; i++)
                zone_cnt[i] <= '0;
            zone_latched <= '0;
            zone_prev    <= '0;
            call_cnt     <= '0;
            call_latched <= 1'b0;
            state        <= ST_IDLE;
            siren        <= 1'b0;
            cad_cnt      <= '0;
            dstate       <= C_IDLE;
            timer        <= '0;
            attempt      <= '0;
            dial_req     <= 1'b0;
            dial_fail    <= 1'b0;
`ifdef ALARM_SILENCE_TIMEOUT_EN
            sil_cnt      <= '0;
`endif
        end else begin
            for (int i = 0; i < ZONES; i++)
                zone_cnt[i] <= zone_cnt_next[i];
            zone_latched <= zone_next;
            zone_prev    <= zone_latched;
            call_cnt     <= call_cnt_next;
            call_latched <= call_latched_next;
            state        <= state_next;
            siren        <= siren_next;
            cad_cnt      <= cad_next;
            dstate       <= dstate_next;
            timer        <= timer_next;
            attempt      <= attempt_next;
            dial_req     <= (dstate_next == C_REQ);
            dial_fail    <= (dstate_next == C_FAIL);
`ifdef ALARM_SILENCE_TIMEOUT_EN
            sil_cnt      <= sil_next;
`endif
        end
    end

    assign alarm_state = state;

endmodule

// File: tb/tb_alarm_dispatch_ctrl.sv
// Self-checking bench for alarm_dispatch_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model built from run lengths, alarm age and dial phase.
module tb_alarm_dispatch_ctrl;

    localparam int ZONES          = 4;
    localparam int PERSIST        = 3;
    localparam int CADENCE        = 8;
    localparam int CALL_TIMEOUT   = 16;
    localparam int MAX_RETRY      = 3;
    localparam int SILENCE_CYCLES = 64;

    localparam int PH_IDLE = 0, PH_REQ = 1, PH_GAP = 2, PH_DONE = 3, PH_FAIL = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [ZONES-1:0] fire_alarm = '0;
    logic             call = 1'b0, silence = 1'b0, clear = 1'b0, dial_ack = 1'b0;
    logic [ZONES-1:0] zone_latched;
    logic             siren, dial_req, dial_fail;
    logic [1:0]       alarm_state;

    int total = 0;
    int bad   = 0;

    int               m_run [ZONES];
    int               m_call_run;
    logic [ZONES-1:0] m_lat, m_prev;
    logic             m_call_lat;
    int               m_state, m_age, m_sil;
    int               m_phase, m_att, m_elap;

    alarm_dispatch_ctrl #(
        .ZONES(ZONES), .PERSIST(PERSIST), .CADENCE(CADENCE),
        .CALL_TIMEOUT(CALL_TIMEOUT), .MAX_RETRY(MAX_RETRY), .SILENCE_CYCLES(SILENCE_CYCLES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .fire_alarm(fire_alarm), .call(call),
        .silence(silence), .clear(clear), .dial_ack(dial_ack),
        .zone_latched(zone_latched), .siren(siren), .dial_req(dial_req),
        .dial_fail(dial_fail), .alarm_state(alarm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < ZONES; i++) m_run[i] = 0;
        m_call_run = 0;
        m_lat = '0; m_prev = '0; m_call_lat = 1'b0;
        m_state = 0; m_age = 0; m_sil = 0;
        m_phase = PH_IDLE; m_att = 0; m_elap = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs the DUT just sampled.
    task automatic model_step();
        logic [ZONES-1:0] lat_n;
        logic             call_n, newl;
        for (int i = 0; i < ZONES; i++) begin
            m_run[i] = fire_alarm[i] ? m_run[i] + 1 : 0;
            lat_n[i] = (m_run[i] >= PERSIST) || (m_lat[i] && !(clear && !fire_alarm[i]));
        end
        m_call_run = call ? m_call_run + 1 : 0;
        call_n = (m_call_run >= PERSIST) || (m_call_lat && !(clear && !call));
        newl = |(m_lat & ~m_prev);
        case (m_state)
            0: if (m_lat != 0) begin m_state = 1; m_age = 0; end
            1: begin
                if (m_lat == 0) m_state = 0;
                else if (silence && !newl) begin m_state = 2; m_sil = 0; end
                else m_age++;
            end
            default: begin
                if (m_lat == 0) m_state = 0;
                else if (newl) begin m_state = 1; m_age = 0; end
`ifdef ALARM_SILENCE_TIMEOUT_EN
                else begin
                    m_sil++;
                    if (m_sil == SILENCE_CYCLES) begin m_state = 1; m_age = 0; end
                end
`endif
            end
        endcase
        case (m_phase)
            PH_IDLE: if (m_call_lat) begin m_phase = PH_REQ; m_att = 1; m_elap = 0; end
            PH_REQ: begin
                if (dial_ack) m_phase = PH_DONE;
                else begin
                    m_elap++;
                    if (m_elap == CALL_TIMEOUT) m_phase = (m_att == MAX_RETRY) ? PH_FAIL : PH_GAP;
                end
            end
            PH_GAP: begin m_phase = PH_REQ; m_att++; m_elap = 0; end
            default: if (!m_call_lat) m_phase = PH_IDLE;
        endcase
        m_prev = m_lat;
        m_lat = lat_n;
        m_call_lat = call_n;
    endtask

    function automatic logic [ZONES+4:0] exp_vec();
        logic s;
        logic [1:0] st;
        s  = (m_state == 1) && (((m_age / CADENCE) % 2) == 0);
        st = m_state[1:0];
        return {m_lat, s, m_phase == PH_REQ, m_phase == PH_FAIL, st};
    endfunction

    task automatic cycle(input logic [ZONES-1:0] f, input logic c, input logic s,
                         input logic cl, input logic a);
        fire_alarm = f; call = c; silence = s; clear = cl; dial_ack = a;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        #3;
        reset_n = 1'b0;
        model_reset();
        fire_alarm = '0; call = 0; silence = 0; clear = 0; dial_ack = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({zone_latched, siren, dial_req, dial_fail, alarm_state} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_in got=%b want=0", {zone_latched, siren, dial_req, dial_fail, alarm_state});
        end
        model_reset();
        reset_n = 1'b1;
        cycle('0, 0, 0, 0, 0);
        total++;
        if ({zone_latched, siren, dial_req, dial_fail, alarm_state} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_idle got=%b want=0", {zone_latched, siren, dial_req, dial_fail, alarm_state});
        end
    endtask

    task automatic test_persistence();
        for (int k = 0; k < 6; k++) begin
            cycle((k == 2) ? 4'b0000 : 4'b0001, 0, 0, 0, 0);
            total++;
            if (zone_latched !== ((k == 5) ? 4'b0001 : 4'b0000) || alarm_state !== 2'b00) begin
                bad++;
                $display("[TB] FAIL persist k=%0d got=%b/%b want=%b/00", k, zone_latched, alarm_state,
                         (k == 5) ? 4'b0001 : 4'b0000);
            end
        end
        cycle('0, 0, 0, 0, 0);
        total++;
        if (alarm_state !== 2'b01 || siren !== 1'b1) begin
            bad++;
            $display("[TB] FAIL alarm_entry got state=%b siren=%b want 01/1", alarm_state, siren);
        end
    endtask

    task automatic test_cadence_silence();
        for (int k = 0; k < 16; k++) begin
            cycle('0, 0, 0, 0, 0);
            total++;
            if (siren !== ((k < 7 || k == 15) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("[TB] FAIL cadence k=%0d got=%b want=%b", k, siren, (k < 7 || k == 15));
            end
        end
        cycle('0, 0, 1, 0, 0);
        total++;
        if (siren !== 1'b0 || alarm_state !== 2'b10) begin
            bad++;
            $display("[TB] FAIL silence got siren=%b state=%b want 0/10", siren, alarm_state);
        end
        for (int k = 0; k < 3; k++) cycle(4'b0100, 0, 0, 0, 0);
        total++;
        if (zone_latched !== 4'b0101 || alarm_state !== 2'b10) begin
            bad++;
            $display("[TB] FAIL new_zone got=%b/%b want 0101/10", zone_latched, alarm_state);
        end
        cycle('0, 0, 0, 0, 0);
        total++;
        if (alarm_state !== 2'b01 || siren !== 1'b1) begin
            bad++;
            $display("[TB] FAIL resound got state=%b siren=%b want 01/1", alarm_state, siren);
        end
    endtask

    task automatic test_clear_live_zone();
        cycle(4'b0100, 0, 0, 1, 0);
        total++;
        if (zone_latched !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL clear_live got=%b want 0100", zone_latched);
        end
        cycle(4'b0100, 0, 0, 0, 0);
        total++;
        if (alarm_state !== 2'b01) begin
            bad++;
            $display("[TB] FAIL clear_live_state got=%b want 01", alarm_state);
        end
        cycle('0, 0, 0, 1, 0);
        total++;
        if (zone_latched !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL clear_all got=%b want 0000", zone_latched);
        end
        cycle('0, 0, 0, 0, 0);
        total++;
        if (alarm_state !== 2'b00 || siren !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clear_idle got state=%b siren=%b want 00/0", alarm_state, siren);
        end
    endtask

    task automatic test_dial_success();
        for (int k = 0; k < 3; k++) cycle('0, 1, 0, 0, 0);
        total++;
        if (dial_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL req_early got=%b want 0", dial_req);
        end
        for (int k = 0; k < 5; k++) begin
            cycle('0, 0, 0, 0, 0);
            total++;
            if (dial_req !== 1'b1) begin
                bad++;
                $display("[TB] FAIL req_hold k=%0d got=%b want 1", k, dial_req);
            end
        end
        cycle('0, 0, 0, 0, 1);
        total++;
        if (dial_req !== 1'b0 || dial_fail !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ack got req=%b fail=%b want 0/0", dial_req, dial_fail);
        end
        cycle('0, 0, 0, 1, 0);
        cycle('0, 0, 0, 0, 0);
    endtask

    task automatic test_dial_failure();
        for (int k = 0; k < 3; k++) cycle('0, 1, 0, 0, 0);
        for (int a = 0; a < MAX_RETRY; a++) begin
            for (int k = 0; k < CALL_TIMEOUT; k++) begin
                cycle('0, 0, 0, 0, 0);
                total++;
                if (dial_req !== 1'b1 || dial_fail !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL window a=%0d k=%0d got req=%b fail=%b want 1/0", a, k, dial_req, dial_fail);
                end
            end
            cycle('0, 0, 0, 0, 0);
            total++;
            if (dial_req !== 1'b0 || dial_fail !== (a == MAX_RETRY - 1)) begin
                bad++;
                $display("[TB] FAIL gap a=%0d got req=%b fail=%b want 0/%0d", a, dial_req, dial_fail,
                         a == MAX_RETRY - 1);
            end
        end
        cycle('0, 0, 0, 0, 1);
        cycle('0, 0, 0, 1, 0);
        total++;
        if (dial_fail !== 1'b1) begin
            bad++;
            $display("[TB] FAIL fail_hold got=%b want 1", dial_fail);
        end
        cycle('0, 0, 0, 0, 0);
        total++;
        if (dial_fail !== 1'b0 || dial_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fail_release got fail=%b req=%b want 0/0", dial_fail, dial_req);
        end
    endtask

    task automatic test_random();
        logic [ZONES-1:0] f = '0;
        logic             c = 1'b0;
        int               ack_den;
        for (int n = 0; n < 1500; n++) begin
            ack_den = (n < 750) ? 5 : 40;
            for (int i = 0; i < ZONES; i++)
                if ($urandom_range(0, 5) == 0) f[i] = !f[i];
            if ($urandom_range(0, 7) == 0) c = !c;
            cycle(f, c, $urandom_range(0, 11) == 0, $urandom_range(0, 14) == 0,
                  $urandom_range(0, ack_den - 1) == 0);
            total++;
            if ({zone_latched, siren, dial_req, dial_fail, alarm_state} !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL random n=%0d got=%b want=%b", n,
                         {zone_latched, siren, dial_req, dial_fail, alarm_state}, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 3; k++) cycle(4'b1111, 1, 0, 0, 0);
        cycle(4'b1111, 0, 0, 0, 0);
        cycle(4'b1111, 0, 0, 0, 0);
        total++;
        if (dial_req !== 1'b1 || alarm_state !== 2'b01 || zone_latched !== 4'b1111) begin
            bad++;
            $display("[TB] FAIL pre_reset got req=%b state=%b zones=%b want 1/01/1111",
                     dial_req, alarm_state, zone_latched);
        end
        #3;
        reset_n = 1'b0;
        #1;
        total++;
        if ({zone_latched, siren, dial_req, dial_fail, alarm_state} !== '0) begin
            bad++;
            $display("[TB] FAIL async_reset got=%b want=0", {zone_latched, siren, dial_req, dial_fail, alarm_state});
        end
        model_reset();
        fire_alarm = '0; call = 0;
        @(negedge clk);
        reset_n = 1'b1;
        cycle('0, 0, 0, 0, 0);
        total++;
        if ({zone_latched, siren, dial_req, dial_fail, alarm_state} !== exp_vec()) begin
            bad++;
            $display("[TB] FAIL post_reset got=%b want=%b",
                     {zone_latched, siren, dial_req, dial_fail, alarm_state}, exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_persistence();
        test_cadence_silence();
        test_clear_live_zone();
        test_dial_success();
        test_dial_failure();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
